array_repack_stream: RTL

//  Parametrised successor to element-by-element array repacking: captures one

---
 rtl/array_repack_pkg.sv | 15 +
 rtl/array_index_walker.sv | 55 +++++
 rtl/array_repack_stream.sv | 115 +++++++++++
 3 files changed

// File: rtl/array_repack_pkg.sv
// Shared types and helpers for the array repack stream.
// Index widths and the two-state frame FSM encoding.
package array_repack_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } repack_state_t;

    // Width of an index counter for a dimension of n entries.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/array_index_walker.sv
// Walks (i,j) over a D0 x D1 array, row- or column-major.
// One step per call; clear returns both indices to zero.
module array_index_walker
    import array_repack_pkg::*;
#(
    parameter int D0        = 2,
    parameter int D1        = 3,
    parameter int COL_MAJOR = 0,
    localparam int IW       = idx_w(D0),
    localparam int JW       = idx_w(D1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          step,
    output logic [IW-1:0] i,
    output logic [JW-1:0] j,
    output logic          last
);

    localparam logic [IW-1:0] IMAX = IW'(D0 - 1);
    localparam logic [JW-1:0] JMAX = JW'(D1 - 1);

    logic i_top;
    logic j_top;

    assign i_top = (i == IMAX);
    assign j_top = (j == JMAX);
    assign last  = i_top && j_top;

    // Index registers: exact wrap at the dimension limits.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            i <= '0;
            j <= '0;
        end else if (step) begin
            if (COL_MAJOR != 0) begin
                if (i_top) begin
                    i <= '0;
                    j <= j_top ? '0 : j + JW'(1);
                end else begin
                    i <= i + IW'(1);
                end
            end else begin
                if (j_top) begin
                    j <= '0;
                    i <= i_top ? '0 : i + IW'(1);
                end else begin
                    j <= j + JW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/array_repack_stream.sv
// Captures a packed [D0][D1][W] frame and streams it
// out one element per cycle with its (i,j) index.
module array_repack_stream
    import array_repack_pkg::*;
#(
    parameter int W         = 4,
    parameter int D0        = 2,
    parameter int D1        = 3,
    parameter int COL_MAJOR = 0,
    localparam int IW       = idx_w(D0),
    localparam int JW       = idx_w(D1),
    localparam int FW       = D0 * D1 * W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [FW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_elem,
    output logic [IW-1:0] out_i,
    output logic [JW-1:0] out_j,
    output logic          out_last
);

    repack_state_t state;
    repack_state_t state_nx;

    logic [FW-1:0] frame;
    logic          accept;
    logic          hs;
    logic [IW-1:0] wi;
    logic [JW-1:0] wj;
    logic          wlast;

    assign accept = in_valid && in_ready;
    assign hs     = out_valid && out_ready;

    array_index_walker #(
        .D0        (D0),
        .D1        (D1),
        .COL_MAJOR (COL_MAJOR)
    ) u_walk (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .step  (hs),
        .i     (wi),
        .j     (wj),
        .last  (wlast)
    );

    assign out_i    = wi;
    assign out_j    = wj;
    assign out_last = out_valid && wlast;

    // Frame latch: whole frame captured on accept only.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame <= '0;
        end else if (accept) begin
            frame <= in_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and handshake outputs; reload on last keeps SEND.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready && wlast) begin
                    in_ready = 1'b1;
                    if (!in_valid) begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Element mux: constant slices selected by exact index match.
    always_comb begin
        out_elem = '0;
        for (int a = 0; a < D0; a++) begin
            for (int b = 0; b < D1; b++) begin
                if (wi == IW'(a) && wj == JW'(b)) begin
                    out_elem = frame[(a*D1+b)*W +: W];
                end
            end
        end
    end

endmodule
